// File: rtl/sr_expander.sv
// sr_expander: chained serial-in/parallel-out expander with manual bit-strobe shifting and a
// handshaked auto-loader that serialises one N-bit word. Optional macro OUT_LATCH_EN adds a hold register.
module sr_expander #(
  parameter int STAGE_W = 10,
  parameter int STAGES  = 2
) (
  input  logic                        cp,
  input  logic                        reset,
  input  logic                        shift_en,
  input  logic                        s_in,
  input  logic                        dir,
  input  logic                        e,
  input  logic                        xfer,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [STAGE_W*STAGES-1:0]   load_data,
  output logic                        busy,
  output logic                        done,
  output logic [STAGE_W*STAGES-1:0]   p_out,
  output logic [STAGES-1:0]           s_out
);
  localparam int N  = STAGE_W * STAGES;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          dir_q;

  logic          do_shift;
  logic          accept;
  logic          bit_in;
  logic          shift_dir;
  logic [CW-1:0] feed_idx;
  logic [N-1:0]  sr_shifted;

  // Handshake: a word transfers on a rising edge where load_valid and load_ready are both high;
  // load_data is not captured, so the source holds it stable until done.
  assign load_ready = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE) && !reset;

  always_ff @(posedge cp) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_shift  = 1'b0;
    accept    = 1'b0;
    bit_in    = s_in;
    shift_dir = dir;
    feed_idx  = dir_q ? cnt : (CNT_LAST - cnt);
    case (state)
      IDLE: begin
        if (load_valid) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end else if (shift_en) begin
          do_shift = 1'b1;
        end
      end
      SHIFT: begin
        // MSB first when shifting up, LSB first when shifting down: both leave sr == load_data.
        do_shift  = 1'b1;
        bit_in    = load_data[feed_idx];
        shift_dir = dir_q;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sr_shifted = shift_dir ? {bit_in, sr[N-1:1]} : {sr[N-2:0], bit_in};

  always_ff @(posedge cp) begin
    if (reset) begin
      sr    <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else begin
      if (do_shift) sr <= sr_shifted;
      if (accept) begin
        dir_q <= dir;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  logic act_dir;
  assign act_dir = (state == IDLE) ? dir : dir_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_tap
    assign s_out[k] = act_dir ? sr[k*STAGE_W] : sr[(k+1)*STAGE_W-1];
  end

`ifdef OUT_LATCH_EN
  logic [N-1:0] hold;

  // xfer samples the pre-shift sr when it coincides with a manual shift.
  always_ff @(posedge cp) begin
    if (reset)                          hold <= '0;
    else if (state == DONE)             hold <= sr;
    else if (state == IDLE && xfer)     hold <= sr;
  end

  assign p_out = e ? hold : '0;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
  assign p_out = e ? sr : '0;
`endif

endmodule

// File: tb/tb_sr_expander.sv
// Randomised self-checking bench for sr_expander against an arithmetic reference model
// (sr after j auto-load shifts is derived directly from the start value and the word).
module tb_sr_expander;
  localparam int W = 10;
  localparam int S = 2;
  localparam int N = W * S;
  localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;

  logic         cp;
  logic         reset;
  logic         shift_en;
  logic         s_in;
  logic         dir;
  logic         e;
  logic         xfer;
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] load_data;
  logic         busy;
  logic         done;
  logic [N-1:0] p_out;
  logic [S-1:0] s_out;

  sr_expander #(.STAGE_W(W), .STAGES(S)) dut (
    .cp(cp), .reset(reset), .shift_en(shift_en), .s_in(s_in), .dir(dir), .e(e),
    .xfer(xfer), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .busy(busy), .done(done), .p_out(p_out), .s_out(s_out)
  );

  // clock / reset block
  initial cp = 1'b0;
  always #5 cp = ~cp;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1);
  end

  // reference model and scoreboard
  logic [63:0]  m_sr;
  logic [63:0]  m_hold;
  logic [N-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [S-1:0] exp_taps(input logic [63:0] v, input logic d);
    logic [S-1:0] t;
    for (int k = 0; k < S; k++) t[k] = d ? v[k*W] : v[(k+1)*W-1];
    return t;
  endfunction

  function automatic logic [63:0] exp_pout(input logic en);
    if (!en) return 64'd0;
`ifdef OUT_LATCH_EN
    return m_hold;
`else
    return m_sr;
`endif
  endfunction

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; shift_en = 1'b0; xfer = 1'b0; e = 1'b1;
    #1;
    check("ready_in_reset", 64'(load_ready), 64'd0);
    check("done_in_reset", 64'(done), 64'd0);
    tick();
    m_sr = 64'd0; m_hold = 64'd0;
    check("pout_reset", 64'(p_out), 64'd0);
    check("taps_reset", 64'(s_out), 64'd0);
    check("busy_reset", 64'(busy), 64'd0);
    check("ready_held_in_reset", 64'(load_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(load_ready), 64'd1);
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_ready"}, 64'(load_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_taps"}, 64'(s_out), 64'(exp_taps(m_sr, dir)));
    check({tag, "_pout"}, 64'(p_out), exp_pout(e));
  endtask

  task automatic manual_shift(input logic b, input logic d, input logic x);
    load_valid = 1'b0; shift_en = 1'b1; s_in = b; dir = d; xfer = x;
    #1;
    idle_checks("manual");
    tick();
`ifdef OUT_LATCH_EN
    if (x) m_hold = m_sr;
`endif
    m_sr = d ? ((m_sr >> 1) | (64'(b) << (N - 1))) : (((m_sr << 1) | 64'(b)) & MASK);
    shift_en = 1'b0; xfer = 1'b0;
  endtask

  task automatic idle_cycle(input logic x);
    load_valid = 1'b0; shift_en = 1'b0; xfer = x;
    #1;
    idle_checks("idle");
    tick();
`ifdef OUT_LATCH_EN
    if (x) m_hold = m_sr;
`endif
    xfer = 1'b0;
  endtask

  task automatic auto_load(input logic [N-1:0] word, input logic d, input logic race_shift);
    logic [63:0] sr0;
    logic [63:0] w64;
    logic [N-1:0] want;
    sr0 = m_sr;
    w64 = 64'(word);
    load_data = word; dir = d; load_valid = 1'b1; xfer = 1'b0;
    shift_en = race_shift ? 1'b1 : 1'($urandom_range(0, 1));
    s_in = 1'($urandom_range(0, 1));
    #1;
    check("ready_at_accept", 64'(load_ready), 64'd1);
    exp_q.push_back(word);
    tick();
    load_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      shift_en = 1'($urandom_range(0, 1)); s_in = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1)); xfer = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 3) != 0);
      if (d) m_sr = (sr0 >> j) | ((w64 << (N - j)) & MASK);
      else   m_sr = ((sr0 << j) & MASK) | (w64 >> (N - j));
      #1;
      check("busy_shift", 64'(busy), 64'd1);
      check("done_shift", 64'(done), 64'd0);
      check("ready_shift", 64'(load_ready), 64'd0);
      check("taps_shift", 64'(s_out), 64'(exp_taps(m_sr, d)));
      check("pout_shift", 64'(p_out), exp_pout(e));
      tick();
    end
    m_sr = w64;
    #1;
    check("done_pulse", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd1);
    check("ready_done", 64'(load_ready), 64'd0);
    check("taps_done", 64'(s_out), 64'(exp_taps(m_sr, d)));
    check("pout_done", 64'(p_out), exp_pout(e));
    tick();
`ifdef OUT_LATCH_EN
    m_hold = m_sr;
`endif
    shift_en = 1'b0; xfer = 1'b0; e = 1'b1;
    #1;
    want = exp_q.pop_front();
    check("word_after_done", 64'(p_out), 64'(want));
    check("done_once", 64'(done), 64'd0);
    check("ready_after_done", 64'(load_ready), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic abort_load(input logic [N-1:0] word, input logic d);
    load_data = word; dir = d; load_valid = 1'b1; shift_en = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int j = 1; j < 8; j++) tick();
    reset = 1'b1;
    #1;
    check("busy_before_abort", 64'(busy), 64'd1);
    check("no_done_in_abort", 64'(done), 64'd0);
    tick();
    reset = 1'b0; e = 1'b1;
    m_sr = 64'd0; m_hold = 64'd0;
    #1;
    check("pout_after_abort", 64'(p_out), 64'd0);
    check("taps_after_abort", 64'(s_out), 64'd0);
    check("ready_after_abort", 64'(load_ready), 64'd1);
    for (int j = 0; j < N + 4; j++) idle_cycle(1'b0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    shift_en = 1'b0; s_in = 1'b0; dir = 1'b0; e = 1'b1; xfer = 1'b0;
    load_valid = 1'b0; load_data = '0; reset = 1'b1;
    m_sr = 64'd0; m_hold = 64'd0;

    do_reset();

    auto_load(20'hA5C3F, 1'b0, 1'b0);
    auto_load(20'h00001, 1'b1, 1'b0);
    auto_load(20'h00001, 1'b0, 1'b1);

    do_reset();
    for (int i = 0; i < 3; i++) manual_shift(1'b1, 1'b0, 1'b0);
    e = 1'b1;
    #1;
`ifdef OUT_LATCH_EN
    check("manual_held", 64'(p_out), 64'd0);
    idle_cycle(1'b1);
    e = 1'b1;
    #1;
`endif
    check("manual_word", 64'(p_out), 64'h00007);
    e = 1'b0;
    #1;
    check("manual_e_low", 64'(p_out), 64'd0);
    e = 1'b1;
    #1;
    check("manual_e_high", 64'(p_out), 64'h00007);

    manual_shift(1'b0, 1'b1, 1'b1);
    idle_cycle(1'b1);

    abort_load(20'h5A5A5, 1'b0);
    auto_load(20'h3C3C3, 1'b1, 1'b1);

    for (int it = 0; it < 40; it++) begin
      e = 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       auto_load(N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1, 2:    manual_shift(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
        default: idle_cycle(1'($urandom_range(0, 1)));
      endcase
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_expander.md
Name: sr_expander

Overview:
- Parametrised successor to the 10-bit serial-in/parallel-out output expander that hangs off the ROM I/O port.
- Chains STAGES expander stages of STAGE_W bits into one N = STAGE_W*STAGES bit register.
- Supports manual bit-strobe shifting in either direction, plus a handshaked auto-loader that serialises a full N-bit word.
- Sits between CPU-driven I/O port bits and board-level parallel outputs; per-stage serial taps support further cascading.

Parameters:
- STAGE_W, 10, bits per stage (>= 2)
- STAGES, 2, number of chained stages (>= 1); N = STAGE_W*STAGES

Ports:
- cp  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- shift_en  input  1  manual shift strobe, one bit per cycle while high
- s_in  input  1  manual serial data in
- dir  input  1  0: shift toward MSB (bit enters at [0]); 1: shift toward LSB (bit enters at [N-1])
- e  input  1  output enable; p_out forced to 0 when low
- xfer  input  1  copy shift register to output hold register (only with OUT_LATCH_EN)
- load_valid  input  1  auto-load request
- load_ready  output  1  high in IDLE and not in reset
- load_data  input  N  word to serialise
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse when auto-load completes
- p_out  output  N  parallel output
- s_out  output  STAGES  per-stage shift-out tap

Behaviour:
- Reset values:
  - sr = 0, hold = 0, state = IDLE, cnt = 0, dir_q = 0.
  - Outputs: p_out = 0, done = 0, busy = 0.
  - load_ready = 0 while reset is high.
- Shift operation:
  - dir 0: sr <= {sr[N-2:0], b}.
  - dir 1: sr <= {b, sr[N-1:1]}.
- s_out[k] is combinational from sr and the active direction:
  - dir 0: s_out[k] = sr[(k+1)*STAGE_W-1].
  - dir 1: s_out[k] = sr[k*STAGE_W].
  - Active direction is dir in IDLE and dir_q in SHIFT/DONE.
- IDLE:
  - If load_valid is high, the word is accepted.
    - dr_q <= dir, cnt <= 0, go to SHIFT.
    - shift_en in the same cycle is discarded; the load wins.
  - Otherwise, if shift_en is high, shift s_in one position per cycle.
- SHIFT:
  - Exactly N cycles, one bit per cycle, cnt counts 0..N-1.
  - Bit order:
    - dir_q 0 feeds load_data[N-1-cnt] (MSB first).
    - dir_q 1 feeds load_data[cnt] (LSB first).
  - Either way, sr == load_data after the final shift.
  - load_data must be held stable by the source until done; it is not captured.
  - shift_en and dir are ignored.
  - On the last shift (cnt == N-1), go to DONE.
- DONE:
  - done = 1 for one cycle, then return to IDLE.
  - With OUT_LATCH_EN, hold <= sr in this cycle.
- Timing:
  - Accept at cycle T; shifts occur at T+1..T+N; done is high at T+N+1.
  - load_ready is high again at T+N+2.
  - Back-to-back loads are therefore N+2 cycles apart.
- busy = (state != IDLE).
- cnt width is clog2(N).
- Reset asserted mid-SHIFT or in DONE:
  - Aborts; next cycle is IDLE with sr = 0.
  - No done pulse; hold is cleared.
- p_out = e ? src : 0, combinational on e.
  - src = sr without the macro; src = hold with the macro.

Optional Feature:
- Macro OUT_LATCH_EN. Defined:
  - A double-buffer hold register drives p_out, so outputs do not ripple while shifting.
  - hold <= sr on the DONE cycle, or on an xfer pulse in IDLE.
  - xfer is ignored in SHIFT/DONE.
  - xfer in the same IDLE cycle as a manual shift copies the pre-shift sr.
- Undefined:
  - No hold register; p_out follows sr live, every shift visible.
  - xfer is ignored.

Test Plan:
- Reset with e = 1 -> p_out = 0, s_out = 0, load_ready = 0 during reset, load_ready = 1 in the cycle after.
- Auto-load 20'hA5C3F, dir = 0 (STAGE_W 10, STAGES 2):
  - done asserts exactly 21 cycles after accept.
  - p_out = 20'hA5C3F once done has asserted.
  - busy is high for cycles 1..21.
- Auto-load 20'h00001, dir = 1 -> final sr = 20'h00001; s_out[0] sequence matches the LSB-first feed; result identical to the dir = 0 case.
- Manual: 3 shift_en pulses of s_in = 1, dir = 0, from 0 -> sr = 20'h00007; then e = 0 -> p_out = 0; then e = 1 -> 20'h00007 (macro off).
- Reset asserted at cycle 8 of a SHIFT -> no done pulse, sr = 0, load_ready = 1 one cycle after reset deasserts; simultaneous load_valid + shift_en in IDLE -> load taken, manual bit dropped.
- OUT_LATCH_EN defined:
  - p_out stays at the previous word throughout SHIFT and switches on the done cycle+1.
  - A manual shift followed by xfer updates p_out only after xfer.
